// File: rtl/banked_sp_ram_ctrl.sv
// Single-port RAM built from a GROUPS x LANES grid of narrow SRAM macros, with a
// req/gnt handshake, one-cycle read-valid strobe, held read data and zero-init.
module banked_sp_ram_ctrl #(
  parameter int RAM_SIZE    = 32768,
  parameter int DATA_WIDTH  = 32,
  parameter int MACRO_DEPTH = 2048,
  parameter int MACRO_WIDTH = 8,
  parameter int INIT_EN     = 1,
  parameter int ADDR_WIDTH  = $clog2(RAM_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  input  logic                    bypass_en_i,
  output logic                    init_done_o
);

  localparam int LANES  = DATA_WIDTH / MACRO_WIDTH;
  localparam int GROUPS = RAM_SIZE / (MACRO_DEPTH * LANES);
  localparam int OFFS   = $clog2(DATA_WIDTH / 8);
  localparam int ROWW   = $clog2(MACRO_DEPTH);
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int BPL    = (MACRO_WIDTH / 8 > 0) ? MACRO_WIDTH / 8 : 1;

  if (DATA_WIDTH % MACRO_WIDTH != 0) begin : g_err_width
    $fatal(1, "DATA_WIDTH must be a multiple of MACRO_WIDTH");
  end
  if (GROUPS < 1) begin : g_err_groups
    $fatal(1, "RAM_SIZE too small for one group of macros");
  end
  if ((RAM_SIZE & (RAM_SIZE - 1)) != 0) begin : g_err_pow2
    $fatal(1, "RAM_SIZE must be a power of two");
  end

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t                  state_q, state_d;
  logic [ROWW-1:0]         cnt_q, cnt_d;
  logic                    init_done_q, init_done_d;
  logic                    rvalid_q, rvalid_d;
  logic [GW-1:0]           grp_q, grp_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;

  logic [ROWW-1:0]         row;
  logic [GW-1:0]           grp_sel;
  logic                    acc;
  logic [LANES-1:0]        lane_be;
  logic [GROUPS-1:0][LANES-1:0] csn, wen;
  logic [ROWW-1:0]         mac_a;
  logic [DATA_WIDTH-1:0]   mac_d;
  logic [GROUPS-1:0][LANES-1:0][MACRO_WIDTH-1:0] mac_q;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^addr_i[OFFS-1:0];
  assign row = addr_i[OFFS+ROWW-1:OFFS];

  if (GROUPS > 1) begin : g_grp
    assign grp_sel = addr_i[ADDR_WIDTH-1:OFFS+ROWW];
  end else begin : g_nogrp
    assign grp_sel = '0;
  end

  assign gnt_o       = (state_q == S_IDLE);
  assign acc         = req_i & gnt_o;
  assign rvalid_o    = rvalid_q;
  assign init_done_o = init_done_q;
  // Registered group picks the macro outputs, so back-to-back reads can alternate groups.
  assign rdata_o     = rvalid_q ? mac_q[grp_q] : hold_q;

  always_comb begin
    lane_be = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_be[l] = |be_i[l*BPL +: BPL];
    end
    csn   = '1;
    wen   = '1;
    mac_a = row;
    mac_d = wdata_i;
    if (state_q == S_INIT) begin
      csn   = '0;
      wen   = '0;
      mac_a = cnt_q;
      mac_d = '0;
    end else if (acc) begin
      for (int g = 0; g < GROUPS; g++) begin
        if (GW'(g) == grp_sel) begin
          for (int l = 0; l < LANES; l++) begin
            if (we_i) begin
              csn[g][l] = ~lane_be[l];
              wen[g][l] = bypass_en_i;
            end else begin
              csn[g][l] = 1'b0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rvalid_d    = acc & ~we_i;
    grp_d       = (acc & ~we_i) ? grp_sel : grp_q;
    hold_d      = rdata_o;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ROWW'(MACRO_DEPTH - 1)) begin
        state_d     = S_IDLE;
        init_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= (INIT_EN != 0) ? S_INIT : S_IDLE;
      cnt_q       <= '0;
      init_done_q <= (INIT_EN != 0) ? 1'b0 : 1'b1;
      rvalid_q    <= 1'b0;
      grp_q       <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rvalid_q    <= rvalid_d;
      grp_q       <= grp_d;
      hold_q      <= hold_d;
    end
  end

  // Behavioural stand-in for the hard macro: active-low CSN/WEN, registered Q,
  // TBYPASS routes D straight to Q on a non-write access.
  for (genvar g = 0; g < GROUPS; g++) begin : g_row
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [MACRO_WIDTH-1:0] mem [MACRO_DEPTH];
      logic [MACRO_WIDTH-1:0] q;
      always_ff @(posedge clk) begin
        if (!csn[g][l]) begin
          if (!wen[g][l]) begin
            mem[mac_a] <= mac_d[l*MACRO_WIDTH +: MACRO_WIDTH];
          end else begin
            q <= bypass_en_i ? mac_d[l*MACRO_WIDTH +: MACRO_WIDTH] : mem[mac_a];
          end
        end
      end
      assign mac_q[g][l] = q;
    end
  end

endmodule
